// File: rtl/tetris_pkg.sv
// Shared keycode constants and action indices used by the keyboard front end
// and the Tetris game-logic block.
package tetris_pkg;

  localparam logic [7:0] KEY_LEFT   = 8'h04;
  localparam logic [7:0] KEY_RIGHT  = 8'h07;
  localparam logic [7:0] KEY_SOFT   = 8'h16;
  localparam logic [7:0] KEY_ROTATE = 8'h1A;
  localparam logic [7:0] KEY_HARD   = 8'h2C;

  localparam int NUM_ACTIONS = 5;

  typedef enum logic [2:0] {
    ACT_LEFT   = 3'd0,
    ACT_RIGHT  = 3'd1,
    ACT_SOFT   = 3'd2,
    ACT_ROTATE = 3'd3,
    ACT_HARD   = 3'd4
  } action_e;

  typedef logic [NUM_ACTIONS-1:0] action_vec_t;

  // A key counts as held if any of the four slots carries its code.
  function automatic logic key_in_slots(input logic [31:0] keycode, input logic [7:0] code);
    key_in_slots = (keycode[31:24] == code) || (keycode[23:16] == code) ||
                   (keycode[15:8]  == code) || (keycode[7:0]   == code);
  endfunction

  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    cnt_width = (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/key_repeat_fsm.sv
// Delayed-auto-shift / auto-repeat sequencer for one key, advanced once per frame tick.
module key_repeat_fsm
  import tetris_pkg::*;
#(
  parameter int DELAY  = 10,
  parameter int REPEAT = 3
) (
  input  logic Clk,
  input  logic Reset,
  input  logic tick,
  input  logic held,
  input  logic press,
  input  logic force_idle,
  output logic emit
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DELAY  = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  localparam int CW = cnt_width(DELAY, REPEAT);
  localparam logic [CW-1:0] DELAY_LAST  = CW'(DELAY - 1);
  localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          emit_d;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    emit_d  = 1'b0;
    if (tick) begin
      if (force_idle) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            emit_d = press | held;
            if (held) begin
              state_d = ST_DELAY;
              cnt_d   = '0;
            end
          end
          ST_DELAY: begin
            if (!held) begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end else if (cnt_q == DELAY_LAST) begin
              emit_d  = 1'b1;
              state_d = ST_REPEAT;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          ST_REPEAT: begin
            if (!held) begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end else if (cnt_q == REPEAT_LAST) begin
              emit_d = 1'b1;
              cnt_d  = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together on the edge regardless of statement order.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign emit = emit_d;

endmodule

// File: rtl/key_action_gen.sv
// Converts the raw USB keycode word into frame-aligned one-cycle Tetris action
// pulses with DAS/auto-repeat for moves and edge-only rotate and hard drop.
module key_action_gen
  import tetris_pkg::*;
#(
  parameter int DAS_FRAMES  = 10,
  parameter int ARR_FRAMES  = 3,
  parameter int SOFT_FRAMES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        vsync,
  input  logic [31:0] keycode,
  input  logic        en,
  output logic        frame_tick,
  output logic        mv_left,
  output logic        mv_right,
  output logic        soft_drop,
  output logic        rotate,
  output logic        hard_drop
);

  logic vs_meta_q, vs_sync_q, vs_prev_q, tick_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      vs_meta_q <= 1'b0;
      vs_sync_q <= 1'b0;
      vs_prev_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      vs_meta_q <= vsync;
      vs_sync_q <= vs_meta_q;
      vs_prev_q <= vs_sync_q;
      tick_q    <= vs_sync_q & ~vs_prev_q;
    end
  end

  action_vec_t held_d, held_q, held_prev_q, rise, press, latch_d, latch_q;

  always_comb begin
    held_d             = '0;
    held_d[ACT_LEFT]   = key_in_slots(keycode, KEY_LEFT);
    held_d[ACT_RIGHT]  = key_in_slots(keycode, KEY_RIGHT);
    held_d[ACT_SOFT]   = key_in_slots(keycode, KEY_SOFT);
    held_d[ACT_ROTATE] = key_in_slots(keycode, KEY_ROTATE);
    held_d[ACT_HARD]   = key_in_slots(keycode, KEY_HARD);
  end

  // A rise in the tick cycle itself counts as a press so it is never dropped.
  assign rise  = held_q & ~held_prev_q;
  assign press = latch_q | rise;

  logic conflict_lr, rot_emit, hard_emit, lr_force, soft_force;
  logic left_emit, right_emit, soft_emit;

  assign conflict_lr = held_q[ACT_LEFT] & held_q[ACT_RIGHT];
  assign rot_emit    = tick_q & en & press[ACT_ROTATE];
  assign hard_emit   = tick_q & en & press[ACT_HARD];
  assign lr_force    = ~en | conflict_lr;
  assign soft_force  = ~en | hard_emit;

  // Move latches only bridge one frame; rotate/hard stay pending across en hold-off.
  always_comb begin
    latch_d             = press;
    latch_d[ACT_LEFT]   = press[ACT_LEFT]  & ~tick_q;
    latch_d[ACT_RIGHT]  = press[ACT_RIGHT] & ~tick_q;
    latch_d[ACT_SOFT]   = press[ACT_SOFT]  & ~tick_q;
    latch_d[ACT_ROTATE] = press[ACT_ROTATE] & ~rot_emit;
    latch_d[ACT_HARD]   = press[ACT_HARD]   & ~hard_emit;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      held_q      <= '0;
      held_prev_q <= '0;
      latch_q     <= '0;
    end else begin
      held_q      <= held_d;
      held_prev_q <= held_q;
      latch_q     <= latch_d;
    end
  end

  key_repeat_fsm #(.DELAY(DAS_FRAMES), .REPEAT(ARR_FRAMES)) u_left (
    .Clk(Clk), .Reset(Reset), .tick(tick_q), .held(held_q[ACT_LEFT]),
    .press(press[ACT_LEFT]), .force_idle(lr_force), .emit(left_emit)
  );

  key_repeat_fsm #(.DELAY(DAS_FRAMES), .REPEAT(ARR_FRAMES)) u_right (
    .Clk(Clk), .Reset(Reset), .tick(tick_q), .held(held_q[ACT_RIGHT]),
    .press(press[ACT_RIGHT]), .force_idle(lr_force), .emit(right_emit)
  );

  key_repeat_fsm #(.DELAY(SOFT_FRAMES), .REPEAT(SOFT_FRAMES)) u_soft (
    .Clk(Clk), .Reset(Reset), .tick(tick_q), .held(held_q[ACT_SOFT]),
    .press(press[ACT_SOFT]), .force_idle(soft_force), .emit(soft_emit)
  );

  assign frame_tick = tick_q;
  assign mv_left    = left_emit;
  assign mv_right   = right_emit;
  assign soft_drop  = soft_emit;
  assign rotate     = rot_emit;
  assign hard_drop  = hard_emit;

endmodule

// File: tb/tb_key_action_gen.sv
// Frame-level bench: each table row is one video frame of stimulus plus the
// action vector expected on that frame's tick.
module tb_key_action_gen;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        vsync;
  logic [31:0] keycode;
  logic        en;
  logic        frame_tick, mv_left, mv_right, soft_drop, rotate, hard_drop;

  always #5 Clk = ~Clk;

  key_action_gen #(.DAS_FRAMES(10), .ARR_FRAMES(3), .SOFT_FRAMES(2)) dut (
    .Clk(Clk), .Reset(Reset), .vsync(vsync), .keycode(keycode), .en(en),
    .frame_tick(frame_tick), .mv_left(mv_left), .mv_right(mv_right),
    .soft_drop(soft_drop), .rotate(rotate), .hard_drop(hard_drop)
  );

  // Expected vector bit order: {hard, rotate, soft, right, left}
  localparam logic [4:0] E_0 = 5'b00000;
  localparam logic [4:0] E_L = 5'b00001;
  localparam logic [4:0] E_R = 5'b00010;
  localparam logic [4:0] E_S = 5'b00100;
  localparam logic [4:0] E_W = 5'b01000;
  localparam logic [4:0] E_H = 5'b10000;

  typedef struct {
    string       name;
    logic [31:0] tap_kc;
    int          tap_n;
    logic [31:0] kc;
    logic        en;
    logic        rst_mid;
    logic [4:0]  exp;
  } vec_t;

  vec_t       vecs[$];
  logic [4:0] exp_q[$];
  int         vectors     = 0;
  int         miscompares = 0;
  int         offtick     = 0;
  string      cur_name    = "reset";
  logic [4:0] act_now;

  assign act_now = {hard_drop, rotate, soft_drop, mv_right, mv_left};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input string name, input logic [31:0] tap_kc, input int tap_n,
                     input logic [31:0] kc, input logic en_v, input logic rst_mid,
                     input logic [4:0] exp);
    vec_t v;
    v.name = name; v.tap_kc = tap_kc; v.tap_n = tap_n; v.kc = kc;
    v.en = en_v; v.rst_mid = rst_mid; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // Scoreboard consumer: one expected vector per tick, no pulses between ticks.
  always @(negedge Clk) begin
    if (!Reset) begin
      if (frame_tick) begin
        check({cur_name, ":pending"}, exp_q.size(), 1);
        if (exp_q.size() > 0) check({cur_name, ":actions"}, 32'(act_now), 32'(exp_q.pop_front()));
      end else if (act_now != 5'b0) begin
        offtick++;
      end
    end
  end

  // 20-cycle frame: taps at the start, vsync high for 4 cycles from cycle 10,
  // optional reset pulse after the tick has been consumed.
  task automatic run_frame(input vec_t v);
    cur_name = v.name;
    en       = v.en;
    keycode  = v.kc;
    exp_q.push_back(v.exp);
    for (int t = 0; t < v.tap_n; t++) begin
      keycode = v.tap_kc;
      step(2);
      keycode = v.kc;
      step(2);
    end
    step(10 - 4 * v.tap_n);
    vsync = 1'b1;
    step(4);
    vsync = 1'b0;
    step(2);
    if (v.rst_mid) begin
      Reset = 1'b1;
      step(1);
      check({v.name, ":mid_reset_outputs"}, 32'({frame_tick, act_now}), 32'(0));
      step(1);
      Reset = 1'b0;
    end else begin
      step(2);
    end
    step(2);
    check({v.name, ":tick_seen"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    Reset   = 1'b1;
    vsync   = 1'b0;
    keycode = 32'h0;
    en      = 1'b1;
    step(3);
    check("reset_outputs", 32'({frame_tick, act_now}), 32'(0));
    Reset = 1'b0;
    step(3);

    add("idle0", 0, 0, 32'h0, 1, 0, E_0);
    add("idle1", 0, 0, 32'h0, 1, 0, E_0);

    for (int f = 1; f <= 20; f++)
      add($sformatf("das_f%0d", f), 0, 0, 32'h04, 1, 0,
          (f == 1 || f == 11 || f == 14 || f == 17 || f == 20) ? E_L : E_0);
    for (int f = 0; f < 3; f++) add("das_release", 0, 0, 32'h0, 1, 0, E_0);

    add("tap_left", 32'h04, 1, 32'h0, 1, 0, E_L);
    add("tap_idle", 0, 0, 32'h0, 1, 0, E_0);

    for (int f = 0; f < 10; f++) add("conflict_ad", 0, 0, 32'h0000_0704, 1, 0, E_0);
    add("conflict_drop_d", 0, 0, 32'h04, 1, 0, E_L);
    add("conflict_clear", 0, 0, 32'h0, 1, 0, E_0);

    add("en_off_taps", 32'h0000_1A16, 2, 32'h16, 0, 0, E_0);
    add("en_on", 0, 0, 32'h16, 1, 0, E_W | E_S);
    add("soft_delay", 0, 0, 32'h16, 1, 0, E_0);
    add("soft_rep1", 0, 0, 32'h16, 1, 0, E_S);
    add("soft_wait", 0, 0, 32'h16, 1, 0, E_0);
    add("soft_rep2", 0, 0, 32'h16, 1, 0, E_S);
    add("soft_clear", 0, 0, 32'h0, 1, 0, E_0);

    add("hard_soft", 0, 0, 32'h0000_2C16, 1, 0, E_H);
    add("hard_held", 0, 0, 32'h0000_2C16, 1, 0, E_S);
    add("hard_clear", 0, 0, 32'h0, 1, 0, E_0);

    add("rot_right", 0, 0, 32'h0000_1A07, 1, 0, E_W | E_R);
    add("rot_right_clear", 0, 0, 32'h0, 1, 0, E_0);
    add("rot_held0", 0, 0, 32'h1A, 1, 0, E_W);
    add("rot_held1", 0, 0, 32'h1A, 1, 0, E_0);
    add("rot_held2", 0, 0, 32'h1A, 1, 0, E_0);
    add("rot_clear", 0, 0, 32'h0, 1, 0, E_0);

    add("en_left_off", 0, 0, 32'h04, 0, 0, E_0);
    add("en_left_on", 0, 0, 32'h04, 1, 0, E_L);
    add("en_left_clear", 0, 0, 32'h0, 1, 0, E_0);

    add("dup_slots", 0, 0, 32'h0404_0404, 1, 0, E_L);
    add("dup_clear", 0, 0, 32'h0, 1, 0, E_0);

    add("rst_pre", 0, 0, 32'h04, 1, 0, E_L);
    add("rst_mid", 0, 0, 32'h04, 1, 1, E_0);
    add("rst_post", 0, 0, 32'h04, 1, 0, E_L);
    add("rst_clear", 0, 0, 32'h0, 1, 0, E_0);

    foreach (vecs[i]) run_frame(vecs[i]);

    check("offtick_pulses", offtick, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
